// File: rtl/fpmul_pkg.sv
// fpmul_sched shared types: operand size codes, op-class helper,
// and the writeback bundle used by the result merger.
package fpmul_pkg;

  localparam logic [2:0] SZ32  = 3'b000;
  localparam logic [2:0] SZ64  = 3'b011;
  // Any size code with bit 2 set selects the 128-bit Q path.
  localparam logic [2:0] SZ128 = 3'b100;

  typedef struct packed {
    logic         q;
    logic         sr;
    logic [127:0] data;
    logic [3:0]   dst;
  } wb_t;

  function automatic logic is_q(
    input logic [2:0] sa,
    input logic [2:0] sb
  );
    return |((sa | sb) & SZ128);
  endfunction

endpackage

// File: rtl/fpmul_sched_if.sv
// fpmul_sched bus bundle: requester side, multiplier issue/result, writeback.
// slave = scheduler, master = issue queues + multiplier + register file.
interface fpmul_sched_if #(
  parameter int NREQ  = 4,
  parameter int LAT_Q = 6
);
  localparam int IDW  = $clog2(NREQ);
  localparam int INFW = $clog2(LAT_Q + 1) + 1;

  logic [NREQ-1:0]     REQ;
  logic [NREQ*128-1:0] REQA;
  logic [NREQ*128-1:0] REQB;
  logic [NREQ*3-1:0]   REQSA;
  logic [NREQ*3-1:0]   REQSB;
  logic [NREQ*4-1:0]   REQDST;
  logic [NREQ-1:0]     GNT;

  logic         ACT;
  logic [127:0] A;
  logic [127:0] B;
  logic [2:0]   SA;
  logic [2:0]   SB;
  logic [3:0]   DSTI;
  logic         MRST;

  logic         RDYSD;
  logic         SR;
  logic [63:0]  RSD;
  logic [3:0]   DSTSD;
  logic         RDYQ;
  logic [127:0] RQ;
  logic [3:0]   DSTQ;

  logic            WBV;
  logic            WBQ;
  logic            WBSR;
  logic [127:0]    WBDATA;
  logic [3:0]      WBDST;
  logic [IDW-1:0]  WBID;
  logic [INFW-1:0] INFL;
  logic            ERR;

  modport slave (
    input  REQ, REQA, REQB, REQSA, REQSB, REQDST,
    input  RDYSD, SR, RSD, DSTSD, RDYQ, RQ, DSTQ,
    output GNT, ACT, A, B, SA, SB, DSTI, MRST,
    output WBV, WBQ, WBSR, WBDATA, WBDST, WBID, INFL, ERR
  );

  modport master (
    output REQ, REQA, REQB, REQSA, REQSB, REQDST,
    output RDYSD, SR, RSD, DSTSD, RDYQ, RQ, DSTQ,
    input  GNT, ACT, A, B, SA, SB, DSTI, MRST,
    input  WBV, WBQ, WBSR, WBDATA, WBDST, WBID, INFL, ERR
  );

endinterface

// File: rtl/fpmul_sched_rr_arb.sv
// rr_arb: combinational round-robin arbiter; search starts one past the
// last granted index. Ports: clk, rst, req in; gnt one-hot, gnt_id, gnt_v out.
module rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_v
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;

  always_comb begin
    gnt_id = '0;
    gnt_v  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!gnt_v && req[(int'(last_q) + k) % N]) begin
        gnt_v  = 1'b1;
        gnt_id = IW'((int'(last_q) + k) % N);
      end
    end
    gnt    = gnt_v ? (N'(1) << gnt_id) : '0;
    last_d = gnt_v ? gnt_id : last_q;
  end

  // Reset to N-1 so requester 0 has first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IW'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/fpmul_sched.sv
// fpmul_sched: issue scheduler + writeback merger for the shared FP multiplier.
// Ports: CLK, RESET (async, active-high); bus (slave) carries requests,
// multiplier issue/results, merged writeback, INFL count and sticky ERR.
module fpmul_sched
  import fpmul_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int LAT_SD = 3,
  parameter int LAT_Q  = 6,
  parameter int IDW    = $clog2(NREQ)
) (
  input logic          CLK,
  input logic          RESET,
  fpmul_sched_if.slave bus
);

  localparam int DW   = $clog2(LAT_Q + 2);
  localparam int INFW = $clog2(LAT_Q + 1) + 1;

  // occ_q bit k: a result lands k+1 cycles after the current ACT slot.
  logic [LAT_Q-1:0] occ_q, occ_d, occ_sh;
  logic [IDW-1:0]   idq_q [LAT_Q];
  logic [IDW-1:0]   idq_d [LAT_Q];
  logic             exp_q, exp_d;
  logic [IDW-1:0]   exp_id_q, exp_id_d;
  logic [DW-1:0]    drain_q, drain_d;

  logic         act_q, act_d;
  logic [127:0] a_q, a_d;
  logic [127:0] b_q, b_d;
  logic [2:0]   sa_q, sa_d;
  logic [2:0]   sb_q, sb_d;
  logic [3:0]   dsti_q, dsti_d;

  wb_t             wb_q, wb_d;
  logic            wbv_q, wbv_d;
  logic [IDW-1:0]  wbid_q, wbid_d;
  logic [INFW-1:0] infl_q, infl_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] cls;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gid;
  logic            gv;
  logic            busy;
  logic            rdy_sd, rdy_q, rdy_any;

  assign busy = (drain_q != '0);

  always_comb begin
    occ_sh = occ_q >> 1;
    cls    = '0;
    elig   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cls[i]  = is_q(bus.REQSA[3*i +: 3], bus.REQSB[3*i +: 3]);
      elig[i] = bus.REQ[i] & ~busy &
                ~(cls[i] ? occ_sh[LAT_Q-1] : occ_sh[LAT_SD-1]);
    end
  end

  rr_arb #(.N(NREQ)) u_arb (
    .clk    (CLK),
    .rst    (RESET),
    .req    (elig),
    .gnt    (gnt),
    .gnt_id (gid),
    .gnt_v  (gv)
  );

  always_comb begin
    occ_d = occ_sh;
    for (int k = 0; k < LAT_Q - 1; k++) idq_d[k] = idq_q[k+1];
    idq_d[LAT_Q-1] = '0;
    act_d  = gv;
    a_d    = a_q;
    b_d    = b_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    dsti_d = dsti_q;
    if (gv) begin
      a_d    = bus.REQA[128*int'(gid) +: 128];
      b_d    = bus.REQB[128*int'(gid) +: 128];
      sa_d   = bus.REQSA[3*int'(gid) +: 3];
      sb_d   = bus.REQSB[3*int'(gid) +: 3];
      dsti_d = bus.REQDST[4*int'(gid) +: 4];
      if (cls[gid]) begin
        occ_d[LAT_Q-1] = 1'b1;
        idq_d[LAT_Q-1] = gid;
      end else begin
        occ_d[LAT_SD-1] = 1'b1;
        idq_d[LAT_SD-1] = gid;
      end
    end

    // Slot falling off bit 0 is the one the multiplier answers next cycle.
    exp_d    = occ_q[0];
    exp_id_d = idq_q[0];
    drain_d  = busy ? drain_q - DW'(1) : drain_q;

    rdy_sd  = bus.RDYSD & ~busy;
    rdy_q   = bus.RDYQ & ~busy;
    rdy_any = rdy_sd | rdy_q;

    wbv_d  = rdy_any;
    wb_d   = wb_q;
    wbid_d = wbid_q;
    if (rdy_q) begin
      wb_d = '{q: 1'b1, sr: 1'b0, data: bus.RQ, dst: bus.DSTQ};
    end else if (rdy_sd) begin
      wb_d = '{q: 1'b0, sr: bus.SR,
               data: {64'd0, bus.RSD}, dst: bus.DSTSD};
    end
    if (rdy_any) wbid_d = exp_id_q;

    err_d = err_q | (rdy_sd & rdy_q) | (rdy_any & ~exp_q) |
            (exp_q & ~rdy_any & ~busy);

    infl_d = infl_q;
    if (gv && !rdy_any)      infl_d = infl_q + INFW'(1);
    else if (!gv && rdy_any) infl_d = infl_q - INFW'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      occ_q    <= '0;
      for (int k = 0; k < LAT_Q; k++) idq_q[k] <= '0;
      exp_q    <= 1'b0;
      exp_id_q <= '0;
      drain_q  <= DW'(LAT_Q + 1);
      act_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      dsti_q   <= '0;
      wb_q     <= '0;
      wbv_q    <= 1'b0;
      wbid_q   <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      for (int k = 0; k < LAT_Q; k++) idq_q[k] <= idq_d[k];
      exp_q    <= exp_d;
      exp_id_q <= exp_id_d;
      drain_q  <= drain_d;
      act_q    <= act_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dsti_q   <= dsti_d;
      wb_q     <= wb_d;
      wbv_q    <= wbv_d;
      wbid_q   <= wbid_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  assign bus.GNT    = gnt;
  assign bus.ACT    = act_q;
  assign bus.A      = a_q;
  assign bus.B      = b_q;
  assign bus.SA     = sa_q;
  assign bus.SB     = sb_q;
  assign bus.DSTI   = dsti_q;
  assign bus.MRST   = ~RESET;
  assign bus.WBV    = wbv_q;
  assign bus.WBQ    = wb_q.q;
  assign bus.WBSR   = wb_q.sr;
  assign bus.WBDATA = wb_q.data;
  assign bus.WBDST  = wb_q.dst;
  assign bus.WBID   = wbid_q;
  assign bus.INFL   = infl_q;
  assign bus.ERR    = err_q;

endmodule
